// File: rtl/pipe_pkg.sv
// Shared definitions for the 32-bit datapath pipeline stages.
//   DATA_W  : datapath width shared by the mux and the stages that follow it
//   state_t : occupancy states of a two-entry skid stage
package pipe_pkg;

  localparam int unsigned DATA_W = 32;

  // Encoding 2'd3 is illegal and recovers to ST_EMPTY.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage : pipe_pkg

// File: rtl/data_reg.sv
// WIDTH-bit load-enable register with synchronous active-low reset to zero.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   i_en  : load enable
//   i_d   : data in
//   o_q   : registered data out
module data_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : data_reg

// File: rtl/mux_skid_reg.sv
// Two-entry skid-buffer pipeline stage downstream of the 32-bit 2:1 datapath mux.
// Full throughput with a registered in_ready; synchronous flush drops held data.
// Optional transfer counter enabled by the MUX_SKID_CNT_EN macro.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_data/in_valid    : producer side (mux output)
//   in_ready            : stage can accept (registered)
//   out_data/out_valid  : consumer side (registered)
//   out_ready           : consumer accepts
//   flush               : synchronous clear of held data
//   xfer_cnt            : count of out_fire events (MUX_SKID_CNT_EN only)
module mux_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
`ifdef MUX_SKID_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush
`ifdef MUX_SKID_CNT_EN
  , output logic [CNT_W-1:0] xfer_cnt
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_en;
  logic             w_skid_en;
  logic             w_main_from_skid;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // Next-state and register-enable decode; flush overrides all transfers.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_en        = 1'b0;
    w_skid_en        = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_main_en   = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_en = 1'b1;
          end else if (w_in_fire) begin
            w_skid_en   = 1'b1;
            w_state_nxt = ST_TWO;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            w_main_en        = 1'b1;
            w_main_from_skid = 1'b1;
            w_state_nxt      = ST_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

  // Handshake flags are registered from the next state so they track r_state exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_in_ready  <= (w_state_nxt != ST_TWO);
    end
  end

  data_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_main_en),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_skid_en),
    .i_d   (in_data),
    .o_q   (w_skid_q)
  );

  assign out_data  = w_main_q;
  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;

`ifdef MUX_SKID_CNT_EN
  logic [CNT_W-1:0] r_xfer_cnt;

  // Counts accepted output words; cleared by reset only, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_out_fire) begin
      r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule : mux_skid_reg

// File: tb/tb_mux_skid_reg.sv
// Directed testbench for mux_skid_reg (optionally built with MUX_SKID_CNT_EN).
module tb_mux_skid_reg;
  import pipe_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] mux_a;
  logic [31:0] mux_b;
  logic        mux_s;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
`ifdef MUX_SKID_CNT_EN
  logic [3:0]  xfer_cnt;
`endif

  int n_checks;
  int n_err;

  // Upstream 2:1 mux feeding the stage.
  assign in_data = mux_s ? mux_b : mux_a;

  mux_skid_reg #(
    .WIDTH (32)
`ifdef MUX_SKID_CNT_EN
    , .CNT_W (4)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush)
`ifdef MUX_SKID_CNT_EN
    , .xfer_cnt (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    mux_s    = 1'b0;
    mux_a    = d;
    in_valid = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    mux_a     = 32'd0;
    mux_b     = 32'd0;
    mux_s     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Reset
    tick();
    tick();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef MUX_SKID_CNT_EN
    check_eq("rst_cnt", 32'(xfer_cnt), 32'd0);
`endif
    rst_n = 1'b1;

    // Pass-through through the mux: a=0 (s=0), then b=12 (s=1)
    out_ready = 1'b1;
    in_valid  = 1'b1;
    mux_a     = 32'd0;
    mux_s     = 1'b0;
    tick();
    check_eq("pt0_valid", 32'(out_valid), 32'd1);
    check_eq("pt0_data", out_data, 32'd0);
    check_eq("pt0_ready", 32'(in_ready), 32'd1);
    mux_b = 32'd12;
    mux_s = 1'b1;
    tick();
    check_eq("pt1_data", out_data, 32'd12);
    check_eq("pt1_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    tick();
    check_eq("pt_drain_valid", 32'(out_valid), 32'd0);

    // Back-pressure: third word refused, head held
    out_ready = 1'b0;
    push(32'h11);
    tick();
    check_eq("bp1_data", out_data, 32'h11);
    check_eq("bp1_ready", 32'(in_ready), 32'd1);
    push(32'h22);
    tick();
    check_eq("bp2_ready", 32'(in_ready), 32'd0);
    check_eq("bp2_data", out_data, 32'h11);
    push(32'h33);
    tick();
    check_eq("bp3_ready", 32'(in_ready), 32'd0);
    check_eq("bp3_data", out_data, 32'h11);
    check_eq("bp3_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check_eq("bp_out22", out_data, 32'h22);
    check_eq("bp_out22_ready", 32'(in_ready), 32'd1);
    tick();
    check_eq("bp_out33", out_data, 32'h33);
    in_valid = 1'b0;
    tick();
    check_eq("bp_drain_valid", 32'(out_valid), 32'd0);
`ifdef MUX_SKID_CNT_EN
    check_eq("bp_cnt", 32'(xfer_cnt), 32'd5);
`endif

    // Flush in TWO with a concurrent input
    out_ready = 1'b0;
    push(32'h11);
    tick();
    push(32'h22);
    tick();
    check_eq("fl_pre_ready", 32'(in_ready), 32'd0);
    push(32'h44);
    flush = 1'b1;
    tick();
    check_eq("fl_valid", 32'(out_valid), 32'd0);
    check_eq("fl_ready", 32'(in_ready), 32'd1);
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("fl_post_valid", 32'(out_valid), 32'd0);
    check_eq("fl_main_hold", out_data, 32'h11);
`ifdef MUX_SKID_CNT_EN
    check_eq("fl_cnt", 32'(xfer_cnt), 32'd5);
`endif

    // Simultaneous in/out fire in ONE
    push(32'hA0);
    tick();
    check_eq("sim_pre", out_data, 32'hA0);
    for (int k = 1; k <= 4; k++) begin
      push(32'(k));
      tick();
      check_eq($sformatf("sim_data%0d", k), out_data, 32'(k));
      check_eq($sformatf("sim_ready%0d", k), 32'(in_ready), 32'd1);
      check_eq($sformatf("sim_valid%0d", k), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check_eq("sim_drain_valid", 32'(out_valid), 32'd0);
`ifdef MUX_SKID_CNT_EN
    check_eq("sim_cnt", 32'(xfer_cnt), 32'd10);

    // Counter wrap at CNT_W=4 after a fresh reset; flush leaves it alone
    rst_n = 1'b0;
    tick();
    tick();
    check_eq("wr_rst_cnt", 32'(xfer_cnt), 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      push(32'(k + 100));
      tick();
    end
    check_eq("wr_cnt16", 32'(xfer_cnt), 32'd0);
    check_eq("wr_last_data", out_data, 32'd116);
    in_valid = 1'b0;
    tick();
    check_eq("wr_cnt17", 32'(xfer_cnt), 32'd1);
    out_ready = 1'b0;
    push(32'h55);
    tick();
    push(32'h66);
    tick();
    flush    = 1'b1;
    in_valid = 1'b0;
    tick();
    flush = 1'b0;
    check_eq("wr_fl_valid", 32'(out_valid), 32'd0);
    check_eq("wr_fl_cnt", 32'(xfer_cnt), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_mux_skid_reg
